web_trigger_sequencer: RTL

Upstream front end of the web shooter. Debounces the raw trigger and refill buttons, and latches fire mode and target count at press time. Issues clean, mutually exclusive trigger/refill level pulses with guaranteed low gaps, sized for the shooter controller's WAITING/CHECK/FIRE/REFILL handshake. Implements auto-repeat for RAPID mode.

---
 rtl/web_trigger_sequencer_pkg.sv | 39 +++
 rtl/web_trigger_sequencer_debouncer.sv | 39 +++
 rtl/web_trigger_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/web_trigger_sequencer_pkg.sv
// Shared encodings for the web shooter front end: fire modes, sequencer
// states and target-count normalisation helpers.
package web_trigger_sequencer_pkg;

  // Fire-mode encoding shared with the shooter controller
  localparam logic [2:0] MODE_SWING    = 3'b000;
  localparam logic [2:0] MODE_RICOCHET = 3'b001;
  localparam logic [2:0] MODE_UNUSED   = 3'b010;
  localparam logic [2:0] MODE_SPLITTER = 3'b011;
  localparam logic [2:0] MODE_RAPID    = 3'b100;
  localparam logic [2:0] MODE_GRENADE  = 3'b101;
  localparam logic [2:0] MODE_TASER    = 3'b110;
  localparam logic [2:0] MODE_TRACER   = 3'b111;

  // Sequencer states
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TRIG_HI    = 3'd1;
  localparam logic [2:0] ST_TRIG_GAP   = 3'd2;
  localparam logic [2:0] ST_RAPID_WAIT = 3'd3;
  localparam logic [2:0] ST_REF_HI     = 3'd4;
  localparam logic [2:0] ST_REF_GAP    = 3'd5;

  // Largest target count the splitter can engage
  localparam logic [4:0] SPLIT_MAX_TGT = 5'd16;

  // The hole in the encoding is treated as the default swing
  function automatic logic [2:0] norm_mode(input logic [2:0] mode);
    return (mode == MODE_UNUSED) ? MODE_SWING : mode;
  endfunction

  // Only the splitter uses a multi-target count; it is kept in 1..16
  function automatic logic [4:0] norm_target(input logic [2:0] mode, input logic [4:0] sel);
    if (mode != MODE_SPLITTER) return 5'd1;
    if (sel == 5'd0)           return 5'd1;
    if (sel > SPLIT_MAX_TGT)   return SPLIT_MAX_TGT;
    return sel;
  endfunction

endpackage

// File: rtl/web_trigger_sequencer_debouncer.sv
// Counter-based button debouncer: the level flips only after DEB_CYCLES
// consecutive samples disagree with it. rise is a one-cycle press strobe
// aligned with the level going high.
module button_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count disagreeing samples; accept the new level once the run is long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= raw;
        rise  <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/web_trigger_sequencer.sv
// Web shooter front end: debounces trigger/refill, latches mode and target
// at press time, and emits mutually exclusive trigger/refill pulses with
// enforced low gaps. RAPID mode auto-repeats while the trigger is held.
module web_trigger_sequencer
  import web_trigger_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 3,
  parameter int GAP_CYCLES   = 3,
  parameter int RAPID_PERIOD = 8,
  parameter int BURST_MAX    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_trigger_raw,
  input  logic       btn_refill_raw,
  input  logic [2:0] mode_sel,
  input  logic [4:0] target_sel,
  output logic       trigger,
  output logic       refill,
  output logic [2:0] fire_mode,
  output logic [4:0] target_cnt,
  output logic       busy,
  output logic [3:0] shot_cnt
);

  // One width covers hold, gap and the shot period (period >= hold + gap)
  localparam int PW = $clog2(RAPID_PERIOD + 1);

  logic          trig_lvl, trig_rise, ref_lvl, ref_rise;
  logic [2:0]    state, st_n;
  logic [PW-1:0] tmr, tmr_n, per, per_n;
  logic [3:0]    shot_n;
  logic [2:0]    mode_n, mode_in;
  logic [4:0]    tgt_n;
  logic          go_shot, keep_firing, per_done;

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_trig (
    .clk(clk), .rst(rst), .raw(btn_trigger_raw), .level(trig_lvl), .rise(trig_rise)
  );

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ref (
    .clk(clk), .rst(rst), .raw(btn_refill_raw), .level(ref_lvl), .rise(ref_rise)
  );

  assign mode_in     = norm_mode(mode_sel);
  assign per_done    = (per == PW'(RAPID_PERIOD - 1));
  assign keep_firing = (fire_mode == MODE_RAPID) && trig_lvl && (shot_cnt < 4'(BURST_MAX));

  // Next-state decode; per counts cycles since the last TRIG_HI entry
  always_comb begin
    st_n    = state;
    tmr_n   = tmr;
    per_n   = per;
    shot_n  = shot_cnt;
    mode_n  = fire_mode;
    tgt_n   = target_cnt;
    go_shot = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ref_rise) begin
          st_n  = ST_REF_HI;
          tmr_n = '0;
        end else if (trig_rise) begin
          st_n   = ST_TRIG_HI;
          tmr_n  = '0;
          per_n  = '0;
          shot_n = 4'd1;
          mode_n = mode_in;
          tgt_n  = norm_target(mode_in, target_sel);
        end
      end
      ST_TRIG_HI: begin
        per_n = per + 1'b1;
        if (tmr == PW'(HOLD_CYCLES - 1)) begin
          st_n  = ST_TRIG_GAP;
          tmr_n = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_TRIG_GAP: begin
        per_n = per + 1'b1;
        if (tmr == PW'(GAP_CYCLES - 1)) begin
          if (!keep_firing)  st_n    = ST_IDLE;
          else if (per_done) go_shot = 1'b1;
          else               st_n    = ST_RAPID_WAIT;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_RAPID_WAIT: begin
        per_n = per + 1'b1;
        if (!trig_lvl)     st_n    = ST_IDLE;
        else if (per_done) go_shot = 1'b1;
      end
      ST_REF_HI: begin
        if (tmr == PW'(HOLD_CYCLES - 1)) begin
          st_n  = ST_REF_GAP;
          tmr_n = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_REF_GAP: begin
        if (tmr == PW'(GAP_CYCLES - 1)) st_n  = ST_IDLE;
        else                            tmr_n = tmr + 1'b1;
      end
      default: st_n = ST_IDLE;
    endcase
    if (go_shot) begin
      st_n   = ST_TRIG_HI;
      tmr_n  = '0;
      per_n  = '0;
      shot_n = (shot_cnt == 4'd15) ? 4'd15 : shot_cnt + 4'd1;
    end
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      per        <= '0;
      trigger    <= 1'b0;
      refill     <= 1'b0;
      busy       <= 1'b0;
      fire_mode  <= MODE_SWING;
      target_cnt <= 5'd1;
      shot_cnt   <= 4'd0;
    end else begin
      state      <= st_n;
      tmr        <= tmr_n;
      per        <= per_n;
      trigger    <= (st_n == ST_TRIG_HI);
      refill     <= (st_n == ST_REF_HI);
      busy       <= (st_n != ST_IDLE);
      fire_mode  <= mode_n;
      target_cnt <= tgt_n;
      shot_cnt   <= shot_n;
    end
  end

endmodule
